// File: rtl/trig_event_sched_pkg.sv
// Shared types and constants for the trigger event scheduler.
// Holds the FSM state enum, the channel-index width helper and reset values.
package trig_event_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OUT  = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_t;

    // Channel index width; never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam logic         RST_EVT_VALID = 1'b0;
    localparam sched_state_t RST_STATE     = ST_IDLE;

endpackage

// File: rtl/trig_edge_chan.sv
// One trigger channel: polarity select, synchroniser, edge detect, pending/overrun.
// Ports: clk, rst_n, trigger, cfg_edge, cfg_en, grant, ovr_clr -> pending, overrun.
module trig_edge_chan
    import trig_event_sched_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trigger,
    input  logic cfg_edge,
    input  logic cfg_en,
    input  logic grant,
    input  logic ovr_clr,
    output logic pending,
    output logic overrun
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   r_pending;
    logic                   r_overrun;
    logic                   w_p;
    logic                   w_edge;
    logic                   w_ovr_set;

    assign w_p       = cfg_edge ? trigger : ~trigger;
    assign w_edge    = r_sync[SYNC_STAGES-1] & ~r_hist;
    // A new edge only overruns if the outstanding request is not consumed now.
    assign w_ovr_set = cfg_en & w_edge & r_pending & ~grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_p};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if (!cfg_en) begin
            r_pending <= 1'b0;
        end else if (w_edge) begin
            r_pending <= 1'b1;
        end else if (grant) begin
            r_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign pending = r_pending;
    assign overrun = r_overrun;

endmodule

// File: rtl/trig_event_sched.sv
// Multi-channel trigger event scheduler: round-robin arbiter, output FSM, gap timer.
// Ports: trigger/cfg_edge/cfg_en in; evt_valid/evt_ch/evt_ready handshake; pending/overrun/ovr_clr status.
module trig_event_sched
    import trig_event_sched_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int GAP_CYCLES  = 4,
    parameter int CH_W        = ch_width(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] trigger,
    input  logic [N_CH-1:0] cfg_edge,
    input  logic [N_CH-1:0] cfg_en,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CH_W-1:0] evt_ch,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] overrun,
    input  logic            ovr_clr
);

    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    sched_state_t    r_state;
    sched_state_t    w_state_nxt;
    logic            r_evt_valid;
    logic            w_valid_nxt;
    logic [CH_W-1:0] r_evt_ch;
    logic [CH_W-1:0] w_ch_nxt;
    logic [CH_W-1:0] r_ptr;
    logic [CH_W-1:0] w_ptr_nxt;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] w_gap_nxt;
    logic [N_CH-1:0] w_pending;
    logic [N_CH-1:0] w_overrun;
    logic [N_CH-1:0] w_grant;
    logic            w_found;
    logic [CH_W-1:0] w_winner;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        trig_edge_chan #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .trigger (trigger[g]),
            .cfg_edge(cfg_edge[g]),
            .cfg_en  (cfg_en[g]),
            .grant   (w_grant[g]),
            .ovr_clr (ovr_clr),
            .pending (w_pending[g]),
            .overrun (w_overrun[g])
        );
    end

    // Round-robin search: first pending channel after the last winner, wrapping.
    always_comb begin
        int v_idx;
        v_idx    = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 1; i <= N_CH; i++) begin
            v_idx = (int'(r_ptr) + i) % N_CH;
            if (!w_found && w_pending[v_idx[CH_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = CH_W'(v_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RST_STATE;
            r_evt_valid <= RST_EVT_VALID;
            r_evt_ch    <= '0;
            r_ptr       <= CH_W'(N_CH - 1);
            r_gap       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_evt_valid <= w_valid_nxt;
            r_evt_ch    <= w_ch_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gap       <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_evt_valid;
        w_ch_nxt    = r_evt_ch;
        w_ptr_nxt   = r_ptr;
        w_gap_nxt   = r_gap;
        w_grant     = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant[w_winner] = 1'b1;
                    w_ch_nxt          = w_winner;
                    w_valid_nxt       = 1'b1;
                    w_ptr_nxt         = w_winner;
                    w_state_nxt       = ST_OUT;
                end
            end
            ST_OUT: begin
                if (r_evt_valid && evt_ready) begin
                    w_valid_nxt = 1'b0;
                    if (GAP_CYCLES == 0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_gap_nxt   = GAP_W'(GAP_CYCLES);
                        w_state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                w_gap_nxt = r_gap - GAP_W'(1);
                // <=1 also recovers from a stray zero count.
                if (r_gap <= GAP_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign evt_valid = r_evt_valid;
    assign evt_ch    = r_evt_ch;
    assign pending   = w_pending;
    assign overrun   = w_overrun;

endmodule
